// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for a Sobel core: keeps two previous rows in a line
// buffer and emits one packed window per interior pixel. Optional macro: SOBEL_WIN_POS_EN.
module sobel_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIX_W-1:0]           pix_in,
  input  logic                       pix_valid,
  input  logic                       pix_sof,
  output logic                       pix_ready,
  output logic [9*PIX_W-1:0]         win_out,
  output logic                       win_valid,
  input  logic                       win_ready,
`ifdef SOBEL_WIN_POS_EN
  output logic [$clog2(IMG_W)-1:0]   win_x,
  output logic [$clog2(IMG_H)-1:0]   win_y,
`endif
  output logic                       frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  // Handshakes: a pixel moves when pix_valid && pix_ready; a window moves when
  // win_valid && win_ready. pix_ready only drops while an unconsumed window is stalled.
  logic                   accept, fire, emit;
  logic [XW-1:0]          x_q, x_d, cur_x;
  logic [YW-1:0]          y_q, y_d, cur_y;
  logic [PIX_W-1:0]       old_a, old_b;
  logic [PIX_W-1:0]       line_a_q [IMG_W];
  logic [PIX_W-1:0]       line_b_q [IMG_W];
  logic [8:0][PIX_W-1:0]  win_reg_q, win_reg_d;
  logic [9*PIX_W-1:0]     win_out_q, win_out_d;
  logic                   win_valid_q, win_valid_d;
  logic                   frame_done_q, frame_done_d;
`ifdef SOBEL_WIN_POS_EN
  logic [XW-1:0]          win_x_q, win_x_d;
  logic [YW-1:0]          win_y_q, win_y_d;
`endif

  assign pix_ready  = !win_valid_q || win_ready;
  assign win_out    = win_out_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
`ifdef SOBEL_WIN_POS_EN
  assign win_x = win_x_q;
  assign win_y = win_y_q;
`endif

  always_comb begin
    // A start-of-frame pixel is (0,0) regardless of where the counters were.
    cur_x = pix_sof ? '0 : x_q;
    cur_y = pix_sof ? '0 : y_q;
    old_a = line_a_q[cur_x];
    old_b = line_b_q[cur_x];

    accept = pix_valid && pix_ready;
    fire   = win_valid_q && win_ready;
    emit   = accept && (cur_x >= X_TWO) && (cur_y >= Y_TWO);

    x_d       = x_q;
    y_d       = y_q;
    win_reg_d = win_reg_q;

    if (accept) begin
      if (cur_x == X_LAST) begin
        x_d = '0;
        y_d = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
      for (int r = 0; r < 3; r++) begin
        win_reg_d[3*r]   = win_reg_q[3*r+1];
        win_reg_d[3*r+1] = win_reg_q[3*r+2];
      end
      win_reg_d[2] = old_b;
      win_reg_d[5] = old_a;
      win_reg_d[8] = pix_in;
    end

    win_out_d = emit ? win_reg_d : win_out_q;
    if (emit)      win_valid_d = 1'b1;
    else if (fire) win_valid_d = 1'b0;
    else           win_valid_d = win_valid_q;
    frame_done_d = emit && (cur_x == X_LAST) && (cur_y == Y_LAST);

`ifdef SOBEL_WIN_POS_EN
    win_x_d = emit ? cur_x - XW'(1) : win_x_q;
    win_y_d = emit ? cur_y - YW'(1) : win_y_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      win_reg_q    <= '0;
      win_out_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SOBEL_WIN_POS_EN
      win_x_q      <= '0;
      win_y_q      <= '0;
`endif
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      win_reg_q    <= win_reg_d;
      win_out_q    <= win_out_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
`ifdef SOBEL_WIN_POS_EN
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
`endif
    end
  end

  // Line buffer is deliberately unreset; rows are trusted only once y >= 2.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_a_q[cur_x] <= pix_in;
      line_b_q[cur_x] <= old_a;
    end
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

- Parametrised streaming 3x3 window generator that feeds the Sobel datapath its 9-pixel (9*PIX_W-bit) window input.
- Accepts one raster-order pixel per handshake and keeps the two previous image rows in an internal line buffer.
- Emits one packed window for every interior pixel: (IMG_W-2)*(IMG_H-2) windows per frame, 304964 for 640x480.
- Replaces host-side window assembly; sits between the pixel source and the Sobel core.

## Interface
Parameters:
- IMG_W, 640, pixels per row; must be >= 3.
- IMG_H, 480, rows per frame; must be >= 3.
- PIX_W, 8, bits per pixel.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- pix_in  input  PIX_W  incoming pixel, raster order.
- pix_valid  input  1  pix_in is valid.
- pix_sof  input  1  qualifies pix_in as pixel (0,0) of a new frame.
- pix_ready  output  1  block can accept a pixel this cycle.
- win_out  output  9*PIX_W  window; slice k = 3*r+c at [PIX_W*k +: PIX_W], r=0 top row, c=0 left column.
- win_valid  output  1  win_out holds an unconsumed window.
- win_ready  input  1  consumer takes the window this cycle.
- frame_done  output  1  one-cycle pulse marking the final window of a frame.

## Operation
- Accept = pix_valid && pix_ready. Output fire = win_valid && win_ready.
- pix_ready = !win_valid || win_ready (combinational; one-deep output register).
- Position counters x in 0..IMG_W-1 and y in 0..IMG_H-1.
  - Widths are $clog2(IMG_W) and $clog2(IMG_H).
  - On accept, x increments. At x = IMG_W-1, x wraps to 0 and y increments.
  - At (IMG_W-1, IMG_H-1), both counters wrap to (0,0).
- pix_sof on an accepted pixel forces that pixel to be (0,0); the counters then advance from there.
- Line buffer: IMG_W entries of 2*PIX_W bits (lineA = row y-1, lineB = row y-2). On accept at column x:
  - Read lineA[x] and lineB[x] before writing.
  - Write lineB[x] <= old lineA[x] and lineA[x] <= pix_in.
- Window register: a 3x3 array shifted left one column on every accept. The new right column is {old lineB[x] (r=0), old lineA[x] (r=1), pix_in (r=2)}.
- Window emit: an accept with x >= 2 and y >= 2 loads win_out and sets win_valid.
  - The window is centred on pixel (x-1, y-1).
  - Slice k=8 is the newest pixel.
- win_valid is cleared by a fire that has no simultaneous emitting accept. Fire and emit in the same cycle: win_valid stays 1 and win_out takes the new window.
- Accepts with x < 2 or y < 2 update the counters and buffers but emit nothing.
- Line buffer contents are not reset. Validity comes from the y >= 2 rule alone.
- Border pixels are never emitted; the output image is (IMG_W-2) x (IMG_H-2).
- Pixel values pass through unmodified; no arithmetic on pixel data.

## Timing
- Reset values: pix_ready=1, win_valid=0, win_out=0, frame_done=0, x=0, y=0, window register=0.
- Latency: win_valid rises 1 cycle after the emitting accept.
- Throughput: 1 pixel and 1 window per cycle when win_ready is held high.
- Backpressure: while win_valid=1 and win_ready=0:
  - pix_ready=0.
  - win_out, the counters and the buffers all hold.
  - No pixel is dropped or duplicated.
- frame_done asserts for exactly one cycle, in the same cycle win_valid rises for the window from pixel (IMG_W-1, IMG_H-1).
- Reset mid-frame: state clears asynchronously. Any pending window is discarded, and the next accepted pixel is (0,0).
- pix_sof mid-frame: the partial frame is abandoned.
  - A pending output window stays valid until it is fired.
  - No window is emitted until new row 2, column 2.

## Configuration
- SOBEL_WIN_POS_EN defined: adds output ports win_x [$clog2(IMG_W)-1:0] and win_y [$clog2(IMG_H)-1:0].
  - They carry the centre coordinates (x-1, y-1) of the window.
  - They are registered with win_out, reset to 0, and hold under backpressure.
- Not defined: these ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Reset: assert reset mid-stream for 2 cycles -> pix_ready=1, win_valid=0, win_out=0, frame_done=0. The next pixel is treated as (0,0).
- Small frame (IMG_W=5, IMG_H=4), pixel value = 5*y+x, win_ready=1 -> exactly 6 windows.
  - First window slices k0..k8 = 0,1,2,5,6,7,10,11,12.
  - Last window = 7,8,9,12,13,14,17,18,19.
  - frame_done pulses once, with the last window.
- Backpressure: same frame, win_ready low for 3 cycles after the first window -> win_out stable at 0..12 and pix_ready=0 throughout. The window sequence is unchanged and complete.
- Full frame (640x480) from img.txt, random win_ready -> exactly 304964 windows.
  - Each window matches the reference model.
  - Output order is row-major.
- pix_sof asserted at pixel (3,2) of a 5x4 frame -> no window until 13 accepts later, i.e. new (2,2). Windows then equal a fresh frame.
- SOBEL_WIN_POS_EN defined, 5x4 frame -> (win_x, win_y) = (1,1),(2,1),(3,1),(1,2),(2,2),(3,2).
